jedro_1_csr: RTL and testbench

Machine-mode CSR unit of the jedro_1 core. It sits directly downstream of the decoder and executes csrrw/csrrs/csrrc and their immediate forms, with the decoder supplying the operand. It holds the M-mode trap state and the cycle/instret counters, and gives the fetch and control logic the trap vector and return address. CSR read data goes to the regfile write-back path.

---
 rtl/jedro_1_csr_pkg.sv | 45 ++++
 rtl/jedro_1_csr_counter64.sv | 41 ++++
 rtl/jedro_1_csr.sv | 181 ++++++++++++++++++
 tb/tb_jedro_1_csr.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jedro_1_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jedro_1_csr_pkg
// Description : Shared types and constants for the jedro_1 machine-mode CSR
//               unit: command encoding, CSR address map, mstatus field
//               positions and the fixed misa value.
// Revision    : 1.0 - initial release
// ============================================================================
package jedro_1_csr_pkg;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_cmd_e;

    // CSR address map
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // mstatus field positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // RV32 with the I extension
    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

endpackage
`default_nettype wire

// File: rtl/jedro_1_csr_counter64.sv
`default_nettype none
// ============================================================================
// Module      : jedro_1_csr_counter64
// Description : 64-bit counter with increment enable and independent write
//               ports for the low and high halves. A write to either half
//               suppresses the increment for the whole counter that cycle;
//               the half not written holds its value.
// Revision    : 1.0 - initial release
// Ports       : clk_i    - clock
//               rstn_i   - asynchronous active-low reset
//               inc_i    - increment enable
//               wr_lo_i  - write wdata_i into bits [31:0]
//               wr_hi_i  - write wdata_i into bits [63:32]
//               wdata_i  - write data
//               count_o  - current 64-bit count
// ============================================================================
module jedro_1_csr_counter64 (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_o <= '0;
        end else if (wr_lo_i) begin
            count_o[31:0] <= wdata_i;
        end else if (wr_hi_i) begin
            count_o[63:32] <= wdata_i;
        end else if (inc_i) begin
            // Full 64-bit add so a low-word overflow carries on the same edge
            count_o <= count_o + 64'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jedro_1_csr.sv
`default_nettype none
// ============================================================================
// Module      : jedro_1_csr
// Description : Machine-mode CSR unit of the jedro_1 core. Executes
//               csrrw/csrrs/csrrc (and immediate forms), holds M-mode trap
//               state and the mcycle/minstret counters.
// Revision    : 1.0 - initial release
// Ports       : clk_i, rstn_i            - clock, async active-low reset
//               cmd_valid_i, cmd_i,
//               addr_i, wdata_i,
//               rs1_is_x0_i              - CSR command from the decoder
//               rdata_o, rdata_valid_o,
//               illegal_o                - registered response (1 cycle)
//               trap_i, trap_cause_i,
//               trap_pc_i, trap_val_i    - trap entry
//               mret_i                   - return from trap
//               instr_ret_i              - instruction retired
//               mtvec_o, mepc_o, mie_o   - state for fetch/control logic
// ============================================================================
module jedro_1_csr
    import jedro_1_csr_pkg::*;
#(
    parameter int unsigned     DATA_WIDTH  = 32,   // only 32 is supported
    parameter logic [31:0]     MTVEC_RESET = 32'h0000_0100,
    parameter int unsigned     HART_ID     = 0
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  cmd_valid_i,
    input  csr_cmd_e              cmd_i,
    input  logic [11:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  rs1_is_x0_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rdata_valid_o,
    output logic                  illegal_o,
    input  logic                  trap_i,
    input  logic [DATA_WIDTH-1:0] trap_cause_i,
    input  logic [DATA_WIDTH-1:0] trap_pc_i,
    input  logic [DATA_WIDTH-1:0] trap_val_i,
    input  logic                  mret_i,
    input  logic                  instr_ret_i,
    output logic [DATA_WIDTH-1:0] mtvec_o,
    output logic [DATA_WIDTH-1:0] mepc_o,
    output logic                  mie_o
);

    logic        mpie;
    logic [31:0] mscratch;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic [31:0] mstatus_rd;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        addr_hit;
    logic        csr_req;
    logic        write_attempt;
    logic        access_illegal;
    logic        do_write;

    // MPP is hard-wired to machine mode; only MIE/MPIE are stored
    always_comb begin
        mstatus_rd                                = '0;
        mstatus_rd[MSTATUS_MIE]                   = mie_o;
        mstatus_rd[MSTATUS_MPIE]                  = mpie;
        mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    always_comb begin
        addr_hit = 1'b1;
        old_val  = '0;
        case (addr_i)
            CSR_MSTATUS:   old_val = mstatus_rd;
            CSR_MISA:      old_val = MISA_VALUE;
            CSR_MTVEC:     old_val = mtvec_o;
            CSR_MSCRATCH:  old_val = mscratch;
            CSR_MEPC:      old_val = mepc_o;
            CSR_MCAUSE:    old_val = mcause;
            CSR_MTVAL:     old_val = mtval;
            CSR_MCYCLE:    old_val = mcycle[31:0];
            CSR_MCYCLEH:   old_val = mcycle[63:32];
            CSR_MINSTRET:  old_val = minstret[31:0];
            CSR_MINSTRETH: old_val = minstret[63:32];
            CSR_MVENDORID,
            CSR_MARCHID,
            CSR_MIMPID:    old_val = '0;
            CSR_MHARTID:   old_val = 32'(HART_ID);
            default:       addr_hit = 1'b0;
        endcase
    end

    always_comb begin
        new_val = old_val;
        case (cmd_i)
            CSR_RW:  new_val = wdata_i;
            CSR_RS:  new_val = old_val | wdata_i;
            CSR_RC:  new_val = old_val & ~wdata_i;
            default: new_val = old_val;
        endcase
    end

    // Trap and mret take the cycle; a concurrent CSR command is dropped
    assign csr_req        = cmd_valid_i && (cmd_i != CSR_NONE) && !trap_i && !mret_i;
    // RS/RC with a zero operand are pure reads, legal even on read-only CSRs
    assign write_attempt  = (cmd_i == CSR_RW) || !rs1_is_x0_i;
    assign access_illegal = !addr_hit || ((addr_i[11:10] == 2'b11) && write_attempt);
    assign do_write       = csr_req && !access_illegal && write_attempt;

    jedro_1_csr_counter64 u_mcycle (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .inc_i   (1'b1),
        .wr_lo_i (do_write && (addr_i == CSR_MCYCLE)),
        .wr_hi_i (do_write && (addr_i == CSR_MCYCLEH)),
        .wdata_i (new_val),
        .count_o (mcycle)
    );

    jedro_1_csr_counter64 u_minstret (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .inc_i   (instr_ret_i),
        .wr_lo_i (do_write && (addr_i == CSR_MINSTRET)),
        .wr_hi_i (do_write && (addr_i == CSR_MINSTRETH)),
        .wdata_i (new_val),
        .count_o (minstret)
    );

    // Response register: old value returned one cycle after the request
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            illegal_o     <= 1'b0;
        end else begin
            rdata_valid_o <= csr_req;
            illegal_o     <= csr_req && access_illegal;
            rdata_o       <= (csr_req && !access_illegal) ? old_val : '0;
        end
    end

    // Architectural state
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mie_o    <= 1'b0;
            mpie     <= 1'b0;
            mtvec_o  <= MTVEC_RESET;
            mscratch <= '0;
            mepc_o   <= '0;
            mcause   <= '0;
            mtval    <= '0;
        end else if (trap_i) begin
            mpie   <= mie_o;
            mie_o  <= 1'b0;
            mepc_o <= trap_pc_i & ~32'h3;
            mcause <= trap_cause_i;
            mtval  <= trap_val_i;
        end else if (mret_i) begin
            mie_o <= mpie;
            mpie  <= 1'b1;
        end else if (do_write) begin
            case (addr_i)
                CSR_MSTATUS: begin
                    mie_o <= new_val[MSTATUS_MIE];
                    mpie  <= new_val[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_o  <= new_val & ~32'h3;
                CSR_MSCRATCH: mscratch <= new_val;
                CSR_MEPC:     mepc_o   <= new_val & ~32'h3;
                CSR_MCAUSE:   mcause   <= new_val;
                CSR_MTVAL:    mtval    <= new_val;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jedro_1_csr.sv
`default_nettype none
// ============================================================================
// Module      : tb_jedro_1_csr
// Description : Self-checking bench for jedro_1_csr. Directed scenarios
//               followed by randomized traffic, all compared against a
//               behavioural model of the CSR file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jedro_1_csr;
    import jedro_1_csr_pkg::*;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
    localparam int unsigned HART      = 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    csr_cmd_e    cmd = CSR_NONE;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        x0 = 1'b0;
    logic        trap = 1'b0;
    logic [31:0] tcause = '0;
    logic [31:0] tpc = '0;
    logic [31:0] tval = '0;
    logic        mret = 1'b0;
    logic        iret = 1'b0;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        illegal;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        mie;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model state
    bit          m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cyc, m_ins;
    bit          e_valid, e_ill;
    logic [31:0] e_rdata;

    jedro_1_csr #(
        .DATA_WIDTH  (32),
        .MTVEC_RESET (MTVEC_RST),
        .HART_ID     (HART)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .cmd_valid_i   (cmd_valid),
        .cmd_i         (cmd),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .rs1_is_x0_i   (x0),
        .rdata_o       (rdata),
        .rdata_valid_o (rdata_valid),
        .illegal_o     (illegal),
        .trap_i        (trap),
        .trap_cause_i  (tcause),
        .trap_pc_i     (tpc),
        .trap_val_i    (tval),
        .mret_i        (mret),
        .instr_ret_i   (iret),
        .mtvec_o       (mtvec),
        .mepc_o        (mepc),
        .mie_o         (mie)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic void model_reset();
        m_mie = 0; m_mpie = 0;
        m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cyc = 0; m_ins = 0;
        e_valid = 0; e_ill = 0; e_rdata = 0;
    endfunction

    function automatic void model_read(input logic [11:0] a, output bit hit, output logic [31:0] v);
        hit = 1;
        v = 0;
        case (a)
            12'h300: v = 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
            12'h301: v = 32'h4000_0100;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'hB00: v = m_cyc[31:0];
            12'hB80: v = m_cyc[63:32];
            12'hB02: v = m_ins[31:0];
            12'hB82: v = m_ins[63:32];
            12'hF11, 12'hF12, 12'hF13: v = 0;
            12'hF14: v = HART;
            default: hit = 0;
        endcase
    endfunction

    // Applies the rules of one clock edge to the model using the driven inputs
    task automatic model_step();
        bit          hit, wa, ill;
        bit          cyc_w = 0, ins_w = 0;
        logic [31:0] old, nv;
        e_valid = 0; e_ill = 0; e_rdata = 0;
        if (!trap && !mret && cmd_valid && cmd != CSR_NONE) begin
            model_read(addr, hit, old);
            wa  = (cmd == CSR_RW) || !x0;
            ill = !hit || (addr[11:10] == 2'b11 && wa);
            e_valid = 1;
            e_ill   = ill;
            e_rdata = ill ? 32'h0 : old;
            if (!ill && wa) begin
                if (cmd == CSR_RW)      nv = wdata;
                else if (cmd == CSR_RS) nv = old | wdata;
                else                    nv = old & ~wdata;
                case (addr)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h305: m_mtvec    = {nv[31:2], 2'b00};
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc     = {nv[31:2], 2'b00};
                    12'h342: m_mcause   = nv;
                    12'h343: m_mtval    = nv;
                    12'hB00: begin m_cyc[31:0]  = nv; cyc_w = 1; end
                    12'hB80: begin m_cyc[63:32] = nv; cyc_w = 1; end
                    12'hB02: begin m_ins[31:0]  = nv; ins_w = 1; end
                    12'hB82: begin m_ins[63:32] = nv; ins_w = 1; end
                    default: ;
                endcase
            end
        end
        if (!cyc_w) m_cyc = m_cyc + 64'd1;
        if (!ins_w && iret) m_ins = m_ins + 64'd1;
        if (trap) begin
            m_mpie = m_mie; m_mie = 0;
            m_mepc = {tpc[31:2], 2'b00};
            m_mcause = tcause; m_mtval = tval;
        end else if (mret) begin
            m_mie = m_mpie; m_mpie = 1;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("rdata_valid", 32'(rdata_valid), 32'(e_valid));
        check("illegal", 32'(illegal), 32'(e_ill));
        if (e_valid) check("rdata", rdata, e_rdata);
        check("mtvec", mtvec, m_mtvec);
        check("mepc", mepc, m_mepc);
        check("mie", 32'(mie), 32'(m_mie));
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd = CSR_NONE; addr = 0; wdata = 0; x0 = 0;
        trap = 0; mret = 0; iret = 0;
    endtask

    task automatic csr_op(input logic [1:0] c, input logic [11:0] a, input logic [31:0] d, input logic z);
        cmd_valid = 1; cmd = csr_cmd_e'(c); addr = a; wdata = d; x0 = z;
        cycle();
        idle_inputs();
    endtask

    task automatic csr_read(input logic [11:0] a);
        csr_op(2'd2, a, 32'h0, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(rdata_valid), 32'h0);
        check({tag, "_illegal"}, 32'(illegal), 32'h0);
        check({tag, "_rdata"}, rdata, 32'h0);
        check({tag, "_mtvec"}, mtvec, MTVEC_RST);
        check({tag, "_mepc"}, mepc, 32'h0);
        check({tag, "_mie"}, 32'(mie), 32'h0);
    endtask

    logic [11:0] addr_list [20] = '{
        12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
        12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF12, 12'hF13,
        12'hF14, 12'h7C0, 12'h000, 12'hF15, 12'hB01, 12'h344
    };

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rstn = 1;

        // Scratch write/readback, mcause untouched
        csr_op(2'd1, 12'h340, 32'h55F, 0);
        check("t1_first_rd", rdata, 32'h0);
        csr_op(2'd1, 12'h340, 32'h0, 0);
        check("t1_second_rd", rdata, 32'h55F);
        csr_read(12'h342);
        check("t1_mcause", rdata, 32'h0);

        // mstatus set/clear of MIE
        csr_op(2'd2, 12'h300, 32'h8, 0);
        check("t2_mie_set", 32'(mie), 32'h1);
        csr_read(12'h300);
        check("t2_mstatus", rdata, 32'h1808);
        csr_op(2'd3, 12'h300, 32'h8, 0);
        check("t2_mie_clr", 32'(mie), 32'h0);
        csr_read(12'h300);
        check("t2_mstatus_clr", rdata, 32'h1800);

        // Trap entry and mret
        csr_op(2'd2, 12'h300, 32'h8, 0);
        trap = 1; tcause = 3; tpc = 32'h1002; tval = 32'hDEAD;
        cycle();
        idle_inputs();
        check("t3_mie_trap", 32'(mie), 32'h0);
        check("t3_mepc", mepc, 32'h1000);
        csr_read(12'h342);
        check("t3_mcause", rdata, 32'h3);
        csr_read(12'h343);
        check("t3_mtval", rdata, 32'hDEAD);
        csr_read(12'h300);
        check("t3_mstatus", rdata, 32'h1880);
        mret = 1;
        cycle();
        idle_inputs();
        check("t3_mie_mret", 32'(mie), 32'h1);
        // trap + mret + CSR command together: only the trap applies
        trap = 1; mret = 1; tcause = 7; tpc = 32'h2000; tval = 0;
        cmd_valid = 1; cmd = CSR_RW; addr = 12'h340; wdata = 32'h123;
        cycle();
        idle_inputs();
        check("t3_both_mie", 32'(mie), 32'h0);
        check("t3_both_valid", 32'(rdata_valid), 32'h0);
        csr_read(12'h340);
        check("t3_dropped_wr", rdata, 32'h0);

        // Read-only and unimplemented accesses
        csr_op(2'd1, 12'hF14, 32'h5, 0);
        check("t4_ro_illegal", 32'(illegal), 32'h1);
        check("t4_ro_rdata", rdata, 32'h0);
        csr_read(12'hF14);
        check("t4_hartid_ill", 32'(illegal), 32'h0);
        check("t4_hartid", rdata, HART);
        csr_op(2'd1, 12'h7C0, 32'h1, 0);
        check("t4_unimpl", 32'(illegal), 32'h1);
        csr_op(2'd1, 12'h301, 32'hFFFF_FFFF, 0);
        check("t4_misa_legal", 32'(illegal), 32'h0);
        csr_read(12'h301);
        check("t4_misa", rdata, 32'h4000_0100);

        // Counters
        csr_op(2'd1, 12'hB00, 32'hFFFF_FFFF, 0);
        cycle();
        csr_read(12'hB80);
        check("t5_carry", rdata, 32'h1);
        csr_op(2'd1, 12'hB80, 32'h7, 0);
        csr_read(12'hB80);
        check("t5_mcycleh", rdata, 32'h7);
        repeat (3) begin
            iret = 1;
            cycle();
            idle_inputs();
        end
        csr_read(12'hB02);
        check("t5_minstret", rdata, 32'h3);

        // Asynchronous reset between edges
        csr_op(2'd1, 12'h305, 32'h203, 0);
        cmd_valid = 1; cmd = CSR_RS; addr = 12'h340; x0 = 1;
        cycle();
        check("t6_pre_valid", 32'(rdata_valid), 32'h1);
        #3;
        rstn = 0;
        #1;
        model_reset();
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        idle_inputs();
        #2;
        rstn = 1;
        csr_read(12'h340);
        check("t6_mscratch", rdata, 32'h0);
        csr_read(12'h305);
        check("t6_mtvec_rd", rdata, MTVEC_RST);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd       = csr_cmd_e'($urandom_range(0, 3));
            addr      = addr_list[$urandom_range(0, 19)];
            x0        = ($urandom_range(0, 3) == 0);
            wdata     = x0 ? 32'h0 : $urandom;
            trap      = ($urandom_range(0, 15) == 0);
            mret      = ($urandom_range(0, 15) == 0);
            tcause    = $urandom;
            tpc       = $urandom;
            tval      = $urandom;
            iret      = $urandom_range(0, 1) == 1;
            cycle();
        end
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
